// File: rtl/mult_seq_32bit_if.sv
// Bus between the control unit and the sequential multiplier.
// Handshake: the master raises start with operands and signed_op valid;
// the slave samples them on that clk edge whenever it is idle or in its
// done cycle. busy stays high while the product is being built and
// start is ignored during that time. done pulses for exactly one cycle
// with hi/lo valid. hi/lo then hold until the next done or reset.
interface mult_seq_32bit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Control-unit side.
    modport master (
        output start, signed_op, a, b,
        input  busy, done, hi, lo
    );

    // Multiplier side.
    modport slave (
        input  start, signed_op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq_32bit.sv
// Iterative shift-add multiplier: one partial-product step per clock.
// Signed operands are reduced to magnitudes at start. The sign is
// reapplied to the 64-bit accumulator on the way into the hi/lo
// registers. RUN holds WIDTH add/shift iterations followed by one
// closing cycle, so done rises 33 edges after the start edge.
module mult_seq_32bit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_seq_32bit_if.slave       mul_bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;

    logic                 w_capture;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_signed_acc;

    // A new operation is accepted from IDLE, or from FIN for back-to-back use.
    assign w_capture = mul_bus.start && ((r_state == S_IDLE) || (r_state == S_FIN));

    // All WIDTH iterations are complete once the counter reaches WIDTH.
    assign w_last = (r_cnt == CNT_W'(WIDTH));

    // Negating the most negative value gives itself, which is the correct unsigned magnitude.
    assign w_mag_a = (mul_bus.signed_op && mul_bus.a[WIDTH-1]) ? (~mul_bus.a + 1'b1) : mul_bus.a;
    assign w_mag_b = (mul_bus.signed_op && mul_bus.b[WIDTH-1]) ? (~mul_bus.b + 1'b1) : mul_bus.b;

    assign w_signed_acc = r_neg ? (~r_acc + 1'b1) : r_acc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mul_bus.start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                if (mul_bus.start) begin
                    w_next = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, shift-add iterations and hi/lo update on entry to FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_prod   <= '0;
        end else begin
            if (w_capture) begin
                r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                r_mplier <= w_mag_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= mul_bus.signed_op & (mul_bus.a[WIDTH-1] ^ mul_bus.b[WIDTH-1]);
            end else if ((r_state == S_RUN) && !w_last) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
            if ((r_state == S_RUN) && w_last) begin
                r_prod <= w_signed_acc;
            end
        end
    end

    assign mul_bus.busy = (r_state == S_RUN);
    assign mul_bus.done = (r_state == S_FIN);
    assign mul_bus.hi   = r_prod[2*WIDTH-1:WIDTH];
    assign mul_bus.lo   = r_prod[WIDTH-1:0];
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Bench for mult_seq_32bit: directed vectors with literal results, a
// random run, and a reference model (plain 64-bit multiplication and a
// queue of pending products with their due cycle) compared every cycle.
module tb_mult_seq_32bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  mult_seq_32bit_if #(.WIDTH(32)) mul_bus();

  mult_seq_32bit dut (
    .clk         (clk),
    .rst         (rst),
    .mul_bus     (mul_bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rst_at_edge = 1'b0;
  logic        armed = 1'b0;
  logic [63:0] exp_q[$];
  int          exp_t[$];
  logic [63:0] hold_val = 64'd0;
  int          done_cnt = 0;
  logic [63:0] last_prod = 64'd0;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: accept starts, schedule results ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_at_edge = rst;
      if (rst) begin
        armed = 1'b1;
        exp_q.delete();
        exp_t.delete();
        hold_val = 64'd0;
      end else if (mul_bus.start && exp_q.size() == 0) begin
        exp_q.push_back(ref_prod(mul_bus.a, mul_bus.b, mul_bus.signed_op));
        exp_t.push_back(cyc + 33);
      end
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        if (rst_at_edge) begin
          chk("rst_busy", 64'(mul_bus.busy), 64'd0);
          chk("rst_done", 64'(mul_bus.done), 64'd0);
          chk("rst_hilo", {mul_bus.hi, mul_bus.lo}, 64'd0);
        end else if (exp_t.size() > 0 && cyc == exp_t[0]) begin
          chk("done_pulse", 64'(mul_bus.done), 64'd1);
          chk("busy_in_done", 64'(mul_bus.busy), 64'd0);
          chk("product", {mul_bus.hi, mul_bus.lo}, exp_q[0]);
          hold_val  = exp_q[0];
          last_prod = {mul_bus.hi, mul_bus.lo};
          void'(exp_q.pop_front());
          void'(exp_t.pop_front());
          done_cnt++;
        end else begin
          chk("done_idle", 64'(mul_bus.done), 64'd0);
          chk("busy", 64'(mul_bus.busy), 64'(exp_q.size() > 0));
          chk("hilo_hold", {mul_bus.hi, mul_bus.lo}, hold_val);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    mul_bus.start     = 1'b1;
    mul_bus.a         = a;
    mul_bus.b         = b;
    mul_bus.signed_op = s;
    @(negedge clk);
    mul_bus.start     = 1'b0;
  endtask

  task automatic wait_done(output logic [63:0] p);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 45 cycles (cycle %0d)", cyc);
    end
    p = last_prod;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] p;
    bit          found;
    int          r;
    logic [31:0] va;
    logic [31:0] vb;

    // Reset with start held high: reset must win.
    rst               = 1'b1;
    mul_bus.start     = 1'b1;
    mul_bus.a         = 32'd5;
    mul_bus.b         = 32'd5;
    mul_bus.signed_op = 1'b0;
    repeat (3) @(negedge clk);
    rst           = 1'b0;
    mul_bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Unsigned max.
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(p);
    chk("umax", p, 64'hFFFF_FFFE_0000_0001);

    // Reset mid-operation at the 10th busy cycle.
    drive_start(32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(mul_bus.busy), 64'd0);
    chk("midrst_hilo", {mul_bus.hi, mul_bus.lo}, 64'd0);
    drive_start(32'd3, 32'd4, 1'b0);
    wait_done(p);
    chk("after_rst", p, 64'd12);

    // Signed mixed.
    drive_start(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(p);
    chk("signed_mixed", p, 64'hFFFF_FFFF_FFFF_FFF1);

    // Signed corner.
    drive_start(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(p);
    chk("signed_corner", p, 64'h4000_0000_0000_0000);

    // Back-to-back with an ignored start during RUN.
    drive_start(32'd6, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    mul_bus.start = 1'b1;
    mul_bus.a     = 32'd100;
    @(negedge clk);
    mul_bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (mul_bus.done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL b2b_first_timeout: got no done expected done within 45 cycles");
    end
    mul_bus.start     = 1'b1;
    mul_bus.a         = 32'd2;
    mul_bus.b         = 32'h8000_0000;
    mul_bus.signed_op = 1'b0;
    #1;
    chk("b2b_first", last_prod, 64'd42);
    @(negedge clk);
    mul_bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("b2b_hold42", {mul_bus.hi, mul_bus.lo}, 64'd42);
    wait_done(p);
    chk("b2b_second", p, 64'h0000_0001_0000_0000);

    // Random run: mixed operands, operand churn and ignored starts while busy.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 5))
        0:       va = 32'h8000_0000;
        1:       va = 32'hFFFF_FFFF;
        2:       va = 32'd0;
        default: va = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       vb = 32'h8000_0000;
        1:       vb = 32'hFFFF_FFFF;
        2:       vb = 32'd1;
        default: vb = $urandom;
      endcase
      drive_start(va, vb, 1'($urandom_range(0, 1)));
      mul_bus.a         = $urandom;
      mul_bus.b         = $urandom;
      mul_bus.signed_op = 1'($urandom_range(0, 1));
      r = $urandom_range(1, 20);
      repeat (r) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        mul_bus.start = 1'b1;
        @(negedge clk);
        mul_bus.start = 1'b0;
      end
      wait_done(p);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
